// File: rtl/tx_rate_pkg.sv
// Shared types and rate codes for the TX clock-select sequencer.
package tx_rate_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StRun,
    StHold,
    StGap,
    StApply,
    StSettle
  } state_e;

  localparam logic [1:0] RATE_OFF  = 2'b00;
  localparam logic [1:0] RATE_LOW  = 2'b01;
  localparam logic [1:0] RATE_MID  = 2'b10;
  localparam logic [1:0] RATE_HIGH = 2'b11;

  // Any code other than RATE_OFF selects a real clock.
  function automatic logic rate_valid(input logic [1:0] rate);
    return rate != RATE_OFF;
  endfunction

endpackage

// File: rtl/tx_rate_ctrl_sync.sv
// Multi-bit N-flop synchroniser with asynchronous active-low clear.
// Bits are synchronised independently; consumers must tolerate skew between bits.
module sync_bits #(
  parameter int unsigned Width  = 1,
  parameter int unsigned Stages = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  logic [Width-1:0] stage_q [Stages];

  // Shift chain; stage 0 captures the asynchronous input.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(Stages); i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q[0] <= d_i;
      for (int i = 1; i < int'(Stages); i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign q_o = stage_q[Stages-1];

endmodule

// File: rtl/tx_rate_ctrl.sv
// Sequencer for the TX clock-select mux: hold serializer, gate clock, switch select,
// let the clock settle, then release the serializer.
module tx_rate_ctrl
  import tx_rate_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned HOLD_CYC    = 16,
  parameter int unsigned GAP_CYC     = 8,
  parameter int unsigned SETTLE_CYC  = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cfg_en,
  input  logic [1:0] cfg_rate,
  output logic       en_TDPU,
  output logic [1:0] txRate,
  output logic       tx_hold,
  output logic       busy,
  output logic       switch_done,
  output logic       rate_err
);

  localparam int unsigned MaxHg  = (HOLD_CYC > GAP_CYC) ? HOLD_CYC : GAP_CYC;
  localparam int unsigned MaxCyc = (MaxHg > SETTLE_CYC) ? MaxHg : SETTLE_CYC;
  localparam int unsigned CntW   = ($clog2(MaxCyc) < 1) ? 1 : $clog2(MaxCyc);

  localparam logic [CntW-1:0] HoldLoad   = CntW'(HOLD_CYC - 1);
  localparam logic [CntW-1:0] GapLoad    = CntW'(GAP_CYC - 1);
  localparam logic [CntW-1:0] SettleLoad = CntW'(SETTLE_CYC - 1);

  logic [2:0] sync_q;
  logic       req_en;
  logic [1:0] req_rate;
  logic       tgt_en;
  logic       tgt_differs;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            act_en_q, act_en_d;
  logic [1:0]      act_rate_q, act_rate_d;
  logic            done_q, done_d;
  logic            rate_err_q;

  sync_bits #(
    .Width  (3),
    .Stages (SYNC_STAGES)
  ) u_sync (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .d_i    ({cfg_en, cfg_rate}),
    .q_o    (sync_q)
  );

  assign req_en   = sync_q[2];
  assign req_rate = sync_q[1:0];
  assign tgt_en   = req_en & rate_valid(req_rate);

  // A disabled target matches any disabled active setting regardless of the rate bits.
  assign tgt_differs = (tgt_en != act_en_q) || (tgt_en && (req_rate != act_rate_q));

  // State, counter, active setting and registered flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      act_en_q   <= 1'b0;
      act_rate_q <= RATE_OFF;
      done_q     <= 1'b0;
      rate_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      act_en_q   <= act_en_d;
      act_rate_q <= act_rate_d;
      done_q     <= done_d;
      rate_err_q <= req_en & (req_rate == RATE_OFF);
    end
  end

  // Next-state logic. The active setting is latched on the edge entering APPLY, so
  // txRate only moves while the clock is gated on both sides of that edge.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    act_en_d   = act_en_q;
    act_rate_d = act_rate_q;
    done_d     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (tgt_en) begin
          state_d    = StApply;
          act_en_d   = 1'b1;
          act_rate_d = req_rate;
        end
      end
      StRun: begin
        if (tgt_differs) begin
          state_d = StHold;
          cnt_d   = HoldLoad;
        end
      end
      StHold: begin
        if (cnt_q == '0) begin
          state_d = StGap;
          cnt_d   = GapLoad;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StGap: begin
        if (cnt_q == '0) begin
          // Last request seen before the switch wins; a disable keeps the old rate.
          state_d  = StApply;
          act_en_d = tgt_en;
          if (tgt_en) begin
            act_rate_d = req_rate;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StApply: begin
        if (act_en_q) begin
          state_d = StSettle;
          cnt_d   = SettleLoad;
        end else begin
          state_d = StIdle;
        end
      end
      StSettle: begin
        if (cnt_q == '0) begin
          if (tgt_differs) begin
            state_d = StHold;
            cnt_d   = HoldLoad;
          end else begin
            state_d = StRun;
            done_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Output decode from the registered state.
  always_comb begin
    en_TDPU = 1'b0;
    busy    = 1'b0;
    unique case (state_q)
      StIdle:   begin en_TDPU = 1'b0; busy = 1'b0; end
      StRun:    begin en_TDPU = 1'b1; busy = 1'b0; end
      StHold:   begin en_TDPU = 1'b1; busy = 1'b1; end
      StGap:    begin en_TDPU = 1'b0; busy = 1'b1; end
      StApply:  begin en_TDPU = 1'b0; busy = 1'b1; end
      StSettle: begin en_TDPU = 1'b1; busy = 1'b1; end
      default:  begin en_TDPU = 1'b0; busy = 1'b0; end
    endcase
  end

  assign tx_hold     = (state_q != StRun);
  assign txRate      = act_rate_q;
  assign switch_done = done_q;
  assign rate_err    = rate_err_q;

endmodule

// File: tb/tb_tx_rate_ctrl.sv
// Directed bench for tx_rate_ctrl with default parameters (2/16/8/32).
module tb_tx_rate_ctrl;

  logic       clk;
  logic       rst_n;
  logic       cfg_en;
  logic [1:0] cfg_rate;
  logic       en_TDPU;
  logic [1:0] txRate;
  logic       tx_hold;
  logic       busy;
  logic       switch_done;
  logic       rate_err;

  int total;
  int bad;
  int done_cnt;
  logic [3:0] saw_rate;
  logic       prev_en;
  logic [1:0] prev_rate;
  logic       prev_rst;

  tx_rate_ctrl u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cfg_en      (cfg_en),
    .cfg_rate    (cfg_rate),
    .en_TDPU     (en_TDPU),
    .txRate      (txRate),
    .tx_hold     (tx_hold),
    .busy        (busy),
    .switch_done (switch_done),
    .rate_err    (rate_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance n active edges and sample 1 ns after the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Invariants and pulse counting, sampled on the inactive edge.
  always @(negedge clk) begin
    if (rst_n && prev_rst) begin
      if (txRate !== prev_rate) begin
        chk("rate_chg_en_before", {31'd0, prev_en}, 32'd0);
        chk("rate_chg_en_after", {31'd0, en_TDPU}, 32'd0);
      end
      if (!en_TDPU) chk("hold_when_gated", {31'd0, tx_hold}, 32'd1);
      if (switch_done) done_cnt++;
      saw_rate[txRate] = 1'b1;
    end
    prev_en   = en_TDPU;
    prev_rate = txRate;
    prev_rst  = rst_n;
  end

  initial begin
    total    = 0;
    bad      = 0;
    done_cnt = 0;
    saw_rate = '0;
    prev_en  = 1'b0;
    prev_rate = 2'b00;
    prev_rst = 1'b0;
    rst_n    = 1'b0;
    cfg_en   = 1'b0;
    cfg_rate = 2'b00;

    // Reset state
    #12;
    chk("rst_en", {31'd0, en_TDPU}, 0);
    chk("rst_rate", {30'd0, txRate}, 0);
    chk("rst_hold", {31'd0, tx_hold}, 1);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_done", {31'd0, switch_done}, 0);
    chk("rst_err", {31'd0, rate_err}, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    step(3);
    chk("idle_busy", {31'd0, busy}, 0);

    // 1: enable at high rate from IDLE
    done_cnt = 0;
    cfg_en = 1'b1; cfg_rate = 2'b11;
    step(2);
    chk("t1_still_idle", {31'd0, busy}, 0);
    step(1);
    chk("t1_apply_busy", {31'd0, busy}, 1);
    chk("t1_apply_rate", {30'd0, txRate}, 3);
    chk("t1_apply_en", {31'd0, en_TDPU}, 0);
    step(1);
    chk("t1_settle_en", {31'd0, en_TDPU}, 1);
    chk("t1_settle_hold", {31'd0, tx_hold}, 1);
    step(31);
    chk("t1_settle_end_hold", {31'd0, tx_hold}, 1);
    chk("t1_settle_end_busy", {31'd0, busy}, 1);
    step(1);
    chk("t1_run_hold", {31'd0, tx_hold}, 0);
    chk("t1_run_done", {31'd0, switch_done}, 1);
    chk("t1_run_busy", {31'd0, busy}, 0);
    step(1);
    chk("t1_done_once", {31'd0, switch_done}, 0);
    chk("t1_done_cnt", done_cnt, 1);

    // 2: RUN at 11 -> 01
    done_cnt = 0;
    cfg_rate = 2'b01;
    step(2);
    chk("t2_pre_hold", {31'd0, tx_hold}, 0);
    step(1);
    chk("t2_hold", {31'd0, tx_hold}, 1);
    chk("t2_hold_en", {31'd0, en_TDPU}, 1);
    step(15);
    chk("t2_hold_last_en", {31'd0, en_TDPU}, 1);
    step(1);
    chk("t2_gap_en", {31'd0, en_TDPU}, 0);
    chk("t2_gap_rate", {30'd0, txRate}, 3);
    step(7);
    chk("t2_gap_last_rate", {30'd0, txRate}, 3);
    step(1);
    chk("t2_apply_rate", {30'd0, txRate}, 1);
    chk("t2_apply_en", {31'd0, en_TDPU}, 0);
    step(1);
    chk("t2_settle_en", {31'd0, en_TDPU}, 1);
    step(31);
    chk("t2_settle_hold", {31'd0, tx_hold}, 1);
    step(1);
    chk("t2_run_hold", {31'd0, tx_hold}, 0);
    chk("t2_run_done", {31'd0, switch_done}, 1);
    step(1);
    chk("t2_done_cnt", done_cnt, 1);

    // 3: RUN at 01 -> 11, redirected to 10 during GAP
    done_cnt = 0;
    saw_rate = '0;
    cfg_rate = 2'b11;
    step(3);
    chk("t3_hold", {31'd0, tx_hold}, 1);
    step(17);
    chk("t3_gap_en", {31'd0, en_TDPU}, 0);
    cfg_rate = 2'b10;
    step(7);
    chk("t3_apply_rate", {30'd0, txRate}, 2);
    step(33);
    chk("t3_run_done", {31'd0, switch_done}, 1);
    step(1);
    chk("t3_done_cnt", done_cnt, 1);
    chk("t3_never_11", {31'd0, saw_rate[3]}, 0);
    chk("t3_final_rate", {30'd0, txRate}, 2);

    // 4: RUN at 10 -> 01, redirected to 11 during SETTLE
    done_cnt = 0;
    cfg_rate = 2'b01;
    step(28);
    chk("t4_settle_en", {31'd0, en_TDPU}, 1);
    chk("t4_settle_rate", {30'd0, txRate}, 1);
    step(12);
    cfg_rate = 2'b11;
    step(20);
    chk("t4_rehold_done", {31'd0, switch_done}, 0);
    chk("t4_rehold_hold", {31'd0, tx_hold}, 1);
    chk("t4_rehold_en", {31'd0, en_TDPU}, 1);
    chk("t4_rehold_busy", {31'd0, busy}, 1);
    step(24);
    chk("t4_apply_rate", {30'd0, txRate}, 3);
    chk("t4_apply_en", {31'd0, en_TDPU}, 0);
    step(1);
    chk("t4_settle2_en", {31'd0, en_TDPU}, 1);
    step(32);
    chk("t4_run_done", {31'd0, switch_done}, 1);
    step(1);
    chk("t4_done_cnt", done_cnt, 1);

    // 5: invalid rate while enabled -> error flag and disable sequence
    done_cnt = 0;
    cfg_rate = 2'b00;
    step(3);
    chk("t5_err", {31'd0, rate_err}, 1);
    chk("t5_hold", {31'd0, tx_hold}, 1);
    step(24);
    chk("t5_apply_rate", {30'd0, txRate}, 3);
    chk("t5_apply_busy", {31'd0, busy}, 1);
    step(1);
    chk("t5_idle_busy", {31'd0, busy}, 0);
    chk("t5_idle_en", {31'd0, en_TDPU}, 0);
    chk("t5_idle_hold", {31'd0, tx_hold}, 1);
    chk("t5_idle_rate", {30'd0, txRate}, 3);
    step(5);
    chk("t5_stay_idle", {31'd0, busy}, 0);
    chk("t5_done_cnt", done_cnt, 0);

    // 6: reset pulse mid-HOLD
    cfg_rate = 2'b10;
    step(36);
    chk("t6_run", {31'd0, tx_hold}, 0);
    cfg_rate = 2'b01;
    step(8);
    chk("t6_in_hold", {31'd0, busy}, 1);
    rst_n = 1'b0;
    #2;
    chk("t6_rst_en", {31'd0, en_TDPU}, 0);
    chk("t6_rst_rate", {30'd0, txRate}, 0);
    chk("t6_rst_hold", {31'd0, tx_hold}, 1);
    chk("t6_rst_busy", {31'd0, busy}, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    step(2);
    chk("t6_restart_idle", {31'd0, busy}, 0);
    step(1);
    chk("t6_restart_apply", {30'd0, txRate}, 1);
    chk("t6_restart_busy", {31'd0, busy}, 1);
    step(1);
    chk("t6_restart_en", {31'd0, en_TDPU}, 1);
    step(32);
    chk("t6_restart_done", {31'd0, switch_done}, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
